// File: rtl/ram_port_arbiter.sv
// Arbiter sharing the single-ported byte-lane core RAM between instruction fetch and load/store.
// One registered command stage and one registered response stage; responses return in acceptance order.
package ram_port_arbiter_pkg;
  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    RAM_MASK_B = 2'd0,
    RAM_MASK_H = 2'd1,
    RAM_MASK_W = 2'd2
  } ram_mask_e;
endpackage

module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned ADDR_LENGTH     = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  input  logic        if_flush,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_rdata,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic        d_req_we,
  input  ram_mask_e   d_req_mask,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output mem_op_e     ram_mem_op,
  output ram_mask_e   ram_mask,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned STREAK_W = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_STREAK_MAX);

  function automatic logic misaligned(input ram_mask_e m, input logic [1:0] off);
    case (m)
      RAM_MASK_H: misaligned = off[0];
      RAM_MASK_W: misaligned = (off != 2'b00);
      default:    misaligned = 1'b0;
    endcase
  endfunction

  // The RAM writes byte lanes, so store data moves from LSB-aligned into its lane.
  function automatic logic [31:0] lane_wdata(input logic [31:0] wdata, input logic [1:0] off);
    lane_wdata = wdata << {off, 3'b000};
  endfunction

  function automatic logic [31:0] format_rdata(input logic [31:0] word, input ram_mask_e m,
                                               input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (m)
      RAM_MASK_B: format_rdata = {24'h0, sh[7:0]};
      RAM_MASK_H: format_rdata = {16'h0, sh[15:0]};
      default:    format_rdata = word;
    endcase
  endfunction

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                force_fetch, d_gnt, if_gnt;

  logic        cmd_vld_q, cmd_vld_d;
  logic        cmd_fetch_q, cmd_fetch_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic        cmd_we_q, cmd_we_d;
  ram_mask_e   cmd_mask_q, cmd_mask_d;
  logic        cmd_err_q, cmd_err_d;

  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_fetch_q, rsp_fetch_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_flush_q, rsp_flush_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  assign force_fetch  = if_req_valid && (streak_q == STREAK_MAX);
  assign d_gnt        = rst_n && d_req_valid && !force_fetch;
  assign if_gnt       = rst_n && if_req_valid && !d_gnt;
  assign d_req_ready  = d_gnt;
  assign if_req_ready = if_gnt;

  always_comb begin
    streak_d = streak_q;
    if (!if_req_valid || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_comb begin
    cmd_vld_d   = d_gnt || if_gnt;
    cmd_fetch_d = cmd_fetch_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_we_d    = cmd_we_q;
    cmd_mask_d  = cmd_mask_q;
    cmd_err_d   = cmd_err_q;
    if (d_gnt) begin
      cmd_fetch_d = 1'b0;
      cmd_addr_d  = d_req_addr;
      cmd_wdata_d = lane_wdata(d_req_wdata, d_req_addr[1:0]);
      cmd_we_d    = d_req_we;
      cmd_mask_d  = d_req_mask;
      cmd_err_d   = misaligned(d_req_mask, d_req_addr[1:0]);
    end else if (if_gnt) begin
      cmd_fetch_d = 1'b1;
      cmd_addr_d  = if_req_addr;
      cmd_wdata_d = '0;
      cmd_we_d    = 1'b0;
      cmd_mask_d  = RAM_MASK_W;
      cmd_err_d   = misaligned(RAM_MASK_W, if_req_addr[1:0]);
    end
  end

  // A flush seen while the fetch is at the RAM is remembered; one seen a cycle later gates the strobe directly.
  always_comb begin
    rsp_vld_d   = cmd_vld_q;
    rsp_fetch_d = rsp_fetch_q;
    rsp_err_d   = rsp_err_q;
    rsp_flush_d = rsp_flush_q;
    rsp_rdata_d = rsp_rdata_q;
    if (cmd_vld_q) begin
      rsp_fetch_d = cmd_fetch_q;
      rsp_err_d   = cmd_err_q;
      rsp_flush_d = cmd_fetch_q && if_flush;
      rsp_rdata_d = (cmd_err_q || cmd_we_q) ? 32'h0
                                            : format_rdata(ram_rdata, cmd_mask_q, cmd_addr_q[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q    <= '0;
      cmd_vld_q   <= 1'b0;
      cmd_fetch_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_we_q    <= 1'b0;
      cmd_mask_q  <= RAM_MASK_W;
      cmd_err_q   <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_fetch_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_flush_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      streak_q    <= streak_d;
      cmd_vld_q   <= cmd_vld_d;
      cmd_fetch_q <= cmd_fetch_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_we_q    <= cmd_we_d;
      cmd_mask_q  <= cmd_mask_d;
      cmd_err_q   <= cmd_err_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_fetch_q <= rsp_fetch_d;
      rsp_err_q   <= rsp_err_d;
      rsp_flush_q <= rsp_flush_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // The RAM decodes only the low ADDR_LENGTH bits; the upper bits ride along untouched.
  assign ram_addr   = {cmd_addr_q[31:ADDR_LENGTH], cmd_addr_q[ADDR_LENGTH-1:0]};
  assign ram_wdata  = cmd_wdata_q;
  assign ram_mask   = cmd_mask_q;
  assign ram_mem_op = (cmd_vld_q && !cmd_err_q) ? (cmd_we_q ? MEM_STORE : MEM_LOAD) : MEM_NONE;

  assign if_rsp_valid = rsp_vld_q && rsp_fetch_q && !rsp_flush_q && !if_flush;
  assign if_rsp_rdata = rsp_rdata_q;
  assign if_rsp_err   = if_rsp_valid && rsp_err_q;
  assign d_rsp_valid  = rsp_vld_q && !rsp_fetch_q;
  assign d_rsp_rdata  = rsp_rdata_q;
  assign d_rsp_err    = d_rsp_valid && rsp_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: byte-lane RAM model, byte-addressed reference memory and an in-order response scoreboard.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic        if_req_ready;
  logic        if_flush = 1'b0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_rdata;
  logic        if_rsp_err;
  logic        d_req_valid = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic [31:0] d_req_wdata = '0;
  logic        d_req_we = 1'b0;
  ram_mask_e   d_req_mask = RAM_MASK_W;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;
  logic        d_rsp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  mem_op_e     ram_mem_op;
  ram_mask_e   ram_mask;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_STREAK_MAX(4), .ADDR_LENGTH(21)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
    .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_req_we(d_req_we), .d_req_mask(d_req_mask), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_mem_op(ram_mem_op),
    .ram_mask(ram_mask), .ram_rdata(ram_rdata)
  );

  // RAM model: word read at the aligned address, lane-enabled writes of lane-positioned data.
  logic [7:0]  ram  [0:4095];
  logic [7:0]  refm [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  wire  [11:0] ra = {ram_addr[11:2], 2'b00};

  assign ram_rdata = {ram[ra + 12'd3], ram[ra + 12'd2], ram[ra + 12'd1], ram[ra]};

  function automatic logic lane_en(input ram_mask_e m, input logic [1:0] off, input int k);
    logic [1:0] kk;
    kk = k[1:0];
    case (m)
      RAM_MASK_B: lane_en = (kk == off);
      RAM_MASK_H: lane_en = (kk[1] == off[1]);
      default:    lane_en = 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (pl_en) begin
      for (int k = 0; k < 4; k++) ram[pl_addr + 12'(k)] <= pl_data[8*k +: 8];
    end else if (ram_mem_op == MEM_STORE) begin
      for (int k = 0; k < 4; k++)
        if (lane_en(ram_mask, ram_addr[1:0], k)) ram[ra + 12'(k)] <= ram_wdata[8*k +: 8];
    end
  end

  function automatic logic [31:0] ram_word(input logic [11:0] a);
    ram_word = {ram[a + 12'd3], ram[a + 12'd2], ram[a + 12'd1], ram[a]};
  endfunction

  function automatic logic bad_align(input ram_mask_e m, input logic [31:0] a);
    bad_align = (m == RAM_MASK_H) ? a[0] : (m == RAM_MASK_W) ? (a[1:0] != 2'b00) : 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input ram_mask_e m);
    logic [11:0] b;
    b = a[11:0];
    case (m)
      RAM_MASK_B: ref_load = {24'h0, refm[b]};
      RAM_MASK_H: ref_load = {16'h0, refm[b + 12'd1], refm[b]};
      default:    ref_load = {refm[b + 12'd3], refm[b + 12'd2], refm[b + 12'd1], refm[b]};
    endcase
  endfunction

  typedef struct {
    logic        fetch;
    logic [31:0] rdata;
    logic        err;
    int          due;
    logic        drop;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t n;
  logic exp_if, exp_d;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    d_req_we     = 1'b0;
    if_flush     = 1'b0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] w);
    pl_en = 1'b1; pl_addr = a; pl_data = w;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic drive_d(input logic [31:0] a, input logic we, input ram_mask_e m,
                         input logic [31:0] wd);
    d_req_valid = 1'b1; d_req_addr = a; d_req_we = we; d_req_mask = m; d_req_wdata = wd;
  endtask

  task automatic test_reset();
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, if_rsp_err, d_rsp_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 000000",
               {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, if_rsp_err, d_rsp_err});
    end
    checks++;
    if (ram_mem_op !== MEM_NONE || ram_mask !== RAM_MASK_W) begin
      errors++;
      $display("FAIL reset_ram_ctrl got op=%0d mask=%0d want op=0 mask=2", ram_mem_op, ram_mask);
    end
    checks++;
    if (ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_ram_bus got addr=%h wdata=%h want 0/0", ram_addr, ram_wdata);
    end
    checks++;
    if (if_rsp_rdata !== 32'h0 || d_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got if=%h d=%h want 0/0", if_rsp_rdata, d_rsp_rdata);
    end
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ready got if=%b d=%b want 1/0", if_req_ready, d_req_ready);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (ram_addr !== 32'h100 || ram_mem_op !== MEM_LOAD) begin
      errors++;
      $display("FAIL fetch_ram_cmd got addr=%h op=%0d want 100/1", ram_addr, ram_mem_op);
    end
    tick();
    @(negedge clk);
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rsp_rdata !== 32'hDEADBEEF || if_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL fetch_rsp got v=%b rdata=%h err=%b want 1/deadbeef/0",
               if_rsp_valid, if_rsp_rdata, if_rsp_err);
    end
    tick();
  endtask

  task automatic test_store_load();
    drive_d(32'h40, 1'b1, RAM_MASK_W, 32'h11223344);
    tick();
    drive_d(32'h41, 1'b0, RAM_MASK_B, 32'h0);
    @(negedge clk);
    checks++;
    if (ram_mem_op !== MEM_STORE || ram_addr !== 32'h40 || ram_wdata !== 32'h11223344) begin
      errors++;
      $display("FAIL store_cmd got op=%0d addr=%h wdata=%h want 2/40/11223344",
               ram_mem_op, ram_addr, ram_wdata);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'h0 || d_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL store_rsp got v=%b rdata=%h err=%b want 1/0/0", d_rsp_valid, d_rsp_rdata, d_rsp_err);
    end
    tick();
    @(negedge clk);
    checks++;
    if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'h33 || d_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL load_b_rsp got v=%b rdata=%h err=%b want 1/33/0", d_rsp_valid, d_rsp_rdata, d_rsp_err);
    end
    checks++;
    if (ram_word(12'h040) !== 32'h11223344) begin
      errors++;
      $display("FAIL store_mem got %h want 11223344", ram_word(12'h040));
    end
    tick();
  endtask

  task automatic test_arbitration();
    int di;
    logic want_f;
    di = 0;
    for (int i = 0; i < 10; i++) begin
      if_req_valid = 1'b1; if_req_addr = 32'h200;
      drive_d(32'(4 * di), 1'b0, RAM_MASK_W, 32'h0);
      want_f = (i == 4) || (i == 9);
      @(negedge clk);
      checks++;
      if (if_req_ready !== want_f || d_req_ready !== !want_f) begin
        errors++;
        $display("FAIL arb_grant[%0d] got if=%b d=%b want if=%b d=%b",
                 i, if_req_ready, d_req_ready, want_f, !want_f);
      end
      if (d_req_ready) di++;
      tick();
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_misaligned();
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) drive_d(32'h43, 1'b0, RAM_MASK_H, 32'h0);
      if (c == 1) begin if_req_valid = 1'b1; if_req_addr = 32'h102; end
      if (c == 2) drive_d(32'h42, 1'b1, RAM_MASK_W, 32'hFFFFFFFF);
      @(negedge clk);
      checks++;
      if (ram_mem_op === MEM_STORE) begin
        errors++;
        $display("FAIL misalign_no_store[%0d] got op=%0d want not 2", c, ram_mem_op);
      end
      if (c == 1) begin
        checks++;
        if (ram_mem_op !== MEM_NONE) begin
          errors++;
          $display("FAIL misalign_op_none got op=%0d want 0", ram_mem_op);
        end
      end
      if (c == 2) begin
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b1 || d_rsp_rdata !== 32'h0) begin
          errors++;
          $display("FAIL misalign_load_h got v=%b err=%b rdata=%h want 1/1/0", d_rsp_valid, d_rsp_err, d_rsp_rdata);
        end
      end
      if (c == 3) begin
        checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_err !== 1'b1 || if_rsp_rdata !== 32'h0) begin
          errors++;
          $display("FAIL misalign_fetch got v=%b err=%b rdata=%h want 1/1/0", if_rsp_valid, if_rsp_err, if_rsp_rdata);
        end
      end
      tick();
    end
    checks++;
    if (ram_word(12'h040) !== 32'h11223344) begin
      errors++;
      $display("FAIL misalign_mem got %h want 11223344", ram_word(12'h040));
    end
  endtask

  task automatic test_flush();
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    tick();
    if_req_addr = 32'h104; if_flush = 1'b1;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (if_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_suppress got v=%b want 0", if_rsp_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rsp_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL flush_next_fetch got v=%b rdata=%h want 1/cafef00d", if_rsp_valid, if_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i[0] == 1'b0) begin
        if_req_valid = 1'b1; if_req_addr = (i[1] ? 32'h104 : 32'h100);
      end else if (i == 3) begin
        drive_d(32'h206, 1'b1, RAM_MASK_H, 32'h0000BEEF);
      end else begin
        drive_d(32'h204 + 32'(i), 1'b0, (i == 5) ? RAM_MASK_B : RAM_MASK_H, 32'h0);
      end
      @(negedge clk);
      checks++;
      if ((if_req_ready | d_req_ready) !== 1'b1) begin
        errors++;
        $display("FAIL b2b_accept[%0d] got if=%b d=%b want one ready", i, if_req_ready, d_req_ready);
      end
      tick();
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    drive_d(32'h80, 1'b1, RAM_MASK_W, 32'hAAAAAAAA);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ram_mem_op !== MEM_NONE || ram_addr !== 32'h0 || ram_wdata !== 32'h0 || ram_mask !== RAM_MASK_W) begin
      errors++;
      $display("FAIL midrst_ram got op=%0d addr=%h wdata=%h mask=%0d want 0/0/0/2",
               ram_mem_op, ram_addr, ram_wdata, ram_mask);
    end
    checks++;
    if ({d_rsp_valid, if_rsp_valid, d_req_ready, if_req_ready} !== 4'b0) begin
      errors++;
      $display("FAIL midrst_strobes got %b want 0000", {d_rsp_valid, if_rsp_valid, d_req_ready, if_req_ready});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ram_word(12'h080) !== 32'h12345678) begin
      errors++;
      $display("FAIL midrst_mem got %h want 12345678", ram_word(12'h080));
    end
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (if_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_accept got %b want 1", if_req_ready);
    end
    tick();
    idle();
    tick();
    @(negedge clk);
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL midrst_fetch got v=%b rdata=%h want 1/deadbeef", if_rsp_valid, if_rsp_rdata);
    end
    tick();
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          cyc++;
          if (!rst_n) begin
            q.delete();
          end else begin
            if (pl_en) for (int k = 0; k < 4; k++) refm[pl_addr + 12'(k)] = pl_data[8*k +: 8];
            if (if_flush)
              foreach (q[i])
                if (q[i].fetch && cyc >= q[i].due - 1 && cyc <= q[i].due) q[i].drop = 1'b1;
            exp_if = 1'b0;
            exp_d  = 1'b0;
            e = '{fetch: 1'b0, rdata: 32'h0, err: 1'b0, due: 0, drop: 1'b0};
            if (q.size() > 0 && q[0].due == cyc) begin
              e = q.pop_front();
              if (e.fetch) exp_if = !e.drop;
              else         exp_d  = 1'b1;
            end
            if (if_rsp_valid || exp_if) begin
              checks++;
              if (if_rsp_valid !== exp_if || if_rsp_rdata !== e.rdata || if_rsp_err !== e.err) begin
                errors++;
                $display("FAIL sb_fetch cyc %0d got v=%b rdata=%h err=%b want v=%b rdata=%h err=%b",
                         cyc, if_rsp_valid, if_rsp_rdata, if_rsp_err, exp_if, e.rdata, e.err);
              end
            end
            if (d_rsp_valid || exp_d) begin
              checks++;
              if (d_rsp_valid !== exp_d || d_rsp_rdata !== e.rdata || d_rsp_err !== e.err) begin
                errors++;
                $display("FAIL sb_data cyc %0d got v=%b rdata=%h err=%b want v=%b rdata=%h err=%b",
                         cyc, d_rsp_valid, d_rsp_rdata, d_rsp_err, exp_d, e.rdata, e.err);
              end
            end
            if (d_req_valid && d_req_ready) begin
              n.fetch = 1'b0;
              n.err   = bad_align(d_req_mask, d_req_addr);
              n.rdata = (n.err || d_req_we) ? 32'h0 : ref_load(d_req_addr, d_req_mask);
              n.due   = cyc + 2;
              n.drop  = 1'b0;
              q.push_back(n);
              if (!n.err && d_req_we)
                for (int k = 0; k < 4; k++)
                  if (k < ((d_req_mask == RAM_MASK_B) ? 1 : (d_req_mask == RAM_MASK_H) ? 2 : 4))
                    refm[d_req_addr[11:0] + 12'(k)] = d_req_wdata[8*k +: 8];
            end
            if (if_req_valid && if_req_ready) begin
              n.fetch = 1'b1;
              n.err   = bad_align(RAM_MASK_W, if_req_addr);
              n.rdata = n.err ? 32'h0 : ref_load(if_req_addr, RAM_MASK_W);
              n.due   = cyc + 2;
              n.drop  = 1'b0;
              q.push_back(n);
            end
          end
        end
      end
      begin : sequencer
        test_reset();
        preload(12'h100, 32'hDEADBEEF);
        preload(12'h104, 32'hCAFEF00D);
        preload(12'h080, 32'h12345678);
        preload(12'h200, 32'hA5A50001);
        preload(12'h204, 32'h8899AABB);
        preload(12'h208, 32'hCCDDEEFF);
        preload(12'h20C, 32'h01020304);
        for (int i = 0; i < 10; i++) preload(12'(4 * i), 32'h1000_0000 + 32'(i * 32'h0101));
        test_single_fetch();
        test_store_load();
        test_arbitration();
        test_misaligned();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        for (int w = 0; w < 10 && q.size() != 0; w++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL drain got %0d pending responses want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join
  end

endmodule
